// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a fixed CLKS_PER_BIT = FCLK/BAUD bit period.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for tx_start
// START  | driving the start bit (0)
// DATA   | shifting out tx_data[0..7], LSB first
// PARITY | driving the even-parity bit (UART_TX_PARITY_EN only)
// STOP   | driving the stop bit (1)
module uart_tx #(
    parameter int BAUD = 1_000_000,
    parameter int FCLK = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx,
    output logic       tx_idle
);

    localparam int CLKS_PER_BIT = FCLK / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (FCLK < 2 * BAUD) begin : g_bad_rate
            $error("uart_tx: FCLK must be at least 2*BAUD");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t           state, state_next;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shreg, shreg_next;
    logic             tx_next;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_next;
`endif

    logic bit_done, last_bit, accept, shift_now;

    assign bit_done  = (bit_cnt == '0);
    assign last_bit  = (bit_idx == 3'd7);
    assign accept    = (state == IDLE) && tx_start;
    assign shift_now = (state == DATA) && bit_done && !last_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            tx_idle  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_cnt_next;
            bit_idx  <= bit_idx_next;
            shreg    <= shreg_next;
            tx       <= tx_next;
            tx_idle  <= (state_next == IDLE);
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (tx_start) state_next = START;
            START:  if (bit_done) state_next = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (bit_done && last_bit) state_next = PARITY;
            PARITY: if (bit_done) state_next = STOP;
`else
            DATA:   if (bit_done && last_bit) state_next = STOP;
`endif
            STOP:   if (bit_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // tx is registered from the next state so the line changes on the same edge as the FSM
    always_comb begin
        shreg_next   = shreg;
        bit_idx_next = bit_idx;
        bit_cnt_next = bit_cnt;
        tx_next      = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_next  = accept ? ^tx_data : parity_q;
`endif

        if (accept)
            shreg_next = tx_data;
        else if (shift_now)
            shreg_next = {1'b0, shreg[7:1]};

        if (shift_now)
            bit_idx_next = bit_idx + 3'd1;
        else if (state_next != DATA)
            bit_idx_next = '0;

        if (state_next == IDLE)
            bit_cnt_next = '0;
        else if ((state_next != state) || bit_done)
            bit_cnt_next = CNT_LOAD;
        else
            bit_cnt_next = bit_cnt - 1'b1;

        case (state_next)
            START:  tx_next = 1'b0;
            DATA:   tx_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected bytes are queued at request time and
// compared against frames decoded from the serial line at bit midpoints.
module tb_uart_tx;

    localparam int BAUD = 1_000_000;
    localparam int FCLK = 50_000_000;
    localparam int CPB  = FCLK / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_LEN = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx, tx_idle;

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] exp_q[$];

    uart_tx #(.BAUD(BAUD), .FCLK(FCLK)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .tx(tx), .tx_idle(tx_idle)
    );

    always #10 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    // Request a frame; returns at the negedge that should be cycle 0 of the start bit.
    task automatic send(input logic [7:0] b, input logic [7:0] after, input bit push, output bit lat_ok);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        if (push) exp_q.push_back(b);
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = after;
        lat_ok   = (tx === 1'b0) && (tx_idle === 1'b0);
    endtask

    // Decode one frame starting at cycle 0 of the start bit; len = cycles until tx_idle rises.
    task automatic capture(output logic [7:0] d, output logic sb, output logic pb,
                           output logic stb, output int len);
        logic [10:0] bits;
        int t;
        bits = '1;
        t = 0;
        while (t < 4 * FRAME_LEN) begin
            @(negedge clk);
            t++;
            if (tx_idle === 1'b1) break;
            if ((t % CPB) == CPB / 2 && (t / CPB) < NBITS) bits[4'(t / CPB)] = tx;
        end
        sb  = bits[0];
        d   = bits[8:1];
        pb  = bits[9];
        stb = bits[4'(NBITS - 1)];
        len = t;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        tx_start = 1'b1;
        tx_data = 8'hC3;
        repeat (10) @(negedge clk);
        tests_run++;
        if (tx !== 1'b1 || tx_idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_hold: tx=%b tx_idle=%b, want 1 1", tx, tx_idle);
        end
        rst = 1'b0;
        tx_start = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_idle !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL reset_quiet: %0d cycles not idle, want 0", bad);
        end
    endtask

    task automatic test_frames();
        logic [7:0] pat[4];
        logic [7:0] d, e;
        logic sb, pb, stb;
        int len;
        bit lat;
        pat = '{8'hFF, 8'h00, 8'hA5, 8'h5A};
        for (int i = 0; i < 4; i++) begin
            send(pat[i], pat[i], 1'b1, lat);
            tests_run++;
            if (!lat) begin
                tests_failed++;
                $display("FAIL frame_latency[%0d]: tx=%b tx_idle=%b, want 0 0", i, tx, tx_idle);
            end
            capture(d, sb, pb, stb, len);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
            tests_run++;
            if (d !== e || sb !== 1'b0 || stb !== 1'b1) begin
                tests_failed++;
                $display("FAIL frame_data[%0d]: got %h start=%b stop=%b, want %h 0 1", i, d, sb, stb, e);
            end
            tests_run++;
            if (len != FRAME_LEN) begin
                tests_failed++;
                $display("FAIL frame_len[%0d]: got %0d cycles, want %0d", i, len, FRAME_LEN);
            end
`ifdef UART_TX_PARITY_EN
            tests_run++;
            if (pb !== ^e) begin
                tests_failed++;
                $display("FAIL frame_parity[%0d]: got %b, want %b", i, pb, ^e);
            end
`endif
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] d, e;
        logic sb, pb, stb;
        int len;
        bit lat;
        send(8'h07, 8'h07, 1'b1, lat);
        capture(d, sb, pb, stb, len);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        tests_run++;
        if (d !== e || pb !== 1'b1 || len != 11 * CPB) begin
            tests_failed++;
            $display("FAIL parity_07: got %h par=%b len=%0d, want %h 1 %0d", d, pb, len, e, 11 * CPB);
        end
    endtask
`endif

    task automatic test_busy_ignore();
        logic [7:0] d, e;
        logic sb, pb, stb;
        int len, bad;
        bit lat;
        send(8'hA5, 8'hA5, 1'b1, lat);
        fork
            capture(d, sb, pb, stb, len);
            begin
                repeat (99) @(negedge clk);
                tx_data  = 8'h3C;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                tx_data  = 8'hA5;
            end
        join
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        tests_run++;
        if (d !== e || sb !== 1'b0 || stb !== 1'b1 || len != FRAME_LEN) begin
            tests_failed++;
            $display("FAIL busy_frame: got %h len=%0d, want %h len=%0d", d, len, e, FRAME_LEN);
        end
        bad = 0;
        repeat (3 * FRAME_LEN) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_idle !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL busy_not_queued: %0d non-idle cycles after frame, want 0", bad);
        end
    endtask

    task automatic test_data_change();
        logic [7:0] d, e;
        logic sb, pb, stb;
        int len;
        bit lat;
        send(8'hA5, 8'h00, 1'b1, lat);
        capture(d, sb, pb, stb, len);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        tests_run++;
        if (d !== e || len != FRAME_LEN) begin
            tests_failed++;
            $display("FAIL data_change: got %h len=%0d, want %h len=%0d", d, len, e, FRAME_LEN);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d, e;
        logic sb, pb, stb;
        int len, bad;
        bit lat;
        send(8'h00, 8'h00, 1'b0, lat);
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        tests_run++;
        if (tx !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_bit3: tx=%b, want 0", tx);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (tx !== 1'b1 || tx_idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset: tx=%b tx_idle=%b, want 1 1", tx, tx_idle);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (FRAME_LEN + 100) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_idle !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL mid_no_resume: %0d non-idle cycles, want 0", bad);
        end
        send(8'h5A, 8'h5A, 1'b1, lat);
        capture(d, sb, pb, stb, len);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        tests_run++;
        if (!lat || d !== e || sb !== 1'b0 || stb !== 1'b1 || len != FRAME_LEN) begin
            tests_failed++;
            $display("FAIL mid_after: got %h lat=%b len=%0d, want %h 1 %0d", d, lat, len, e, FRAME_LEN);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d, e;
        logic sb, pb, stb;
        int len;
        @(negedge clk);
        tx_data  = 8'h96;
        tx_start = 1'b1;
        exp_q.push_back(8'h96);
        @(negedge clk);
        capture(d, sb, pb, stb, len);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        tests_run++;
        if (d !== e || len != FRAME_LEN) begin
            tests_failed++;
            $display("FAIL b2b_first: got %h len=%0d, want %h len=%0d", d, len, e, FRAME_LEN);
        end
        tx_data = 8'h69;
        exp_q.push_back(8'h69);
        @(negedge clk);
        tx_start = 1'b0;
        tests_run++;
        if (tx !== 1'b0 || tx_idle !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_gap: tx=%b tx_idle=%b one cycle after idle, want 0 0", tx, tx_idle);
        end
        capture(d, sb, pb, stb, len);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        tests_run++;
        if (d !== e || sb !== 1'b0 || stb !== 1'b1 || len != FRAME_LEN) begin
            tests_failed++;
            $display("FAIL b2b_second: got %h len=%0d, want %h len=%0d", d, len, e, FRAME_LEN);
        end
    endtask

    initial begin
        test_reset();
        test_frames();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_busy_ignore();
        test_data_change();
        test_reset_mid();
        test_back_to_back();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d frames left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
